pattern_display: RTL

Parametrised test-pattern generator for the VGA output path, placed between the display timing generator and the DAC/pin drivers. It maps the current pixel coordinate to an RGB value in one of four selectable patterns. Its frame-paced colour cycler ping-pongs cleanly between 0 and full scale. Pattern selection is latched only at frame boundaries so a mode change never tears a frame.

---
 rtl/display_pkg.sv | 17 +
 rtl/color_cycler.sv | 54 +++++
 rtl/pattern_display.sv | 123 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display test-pattern path: pattern modes and
// the colour-bar table (3-bit on/off masks, bit 2 = red, bit 1 = green, bit 0 = blue).
package display_pkg;

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRAY     = 2'd3
  } mode_e;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [2:0] BAR_RGB [0:7] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/color_cycler.sv
// Frame-paced ping-pong colour index: steps once every FRAME_CNT frame pulses,
// running 0..MAX..0 without repeating either endpoint.
module color_cycler #(
  parameter int CW        = 4,
  parameter int FRAME_CNT = 60
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame,
  output logic [CW-1:0] o_idx,
  output logic          o_dir
);

  localparam int FW = (FRAME_CNT > 1) ? $clog2(FRAME_CNT) : 1;
  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  logic [FW-1:0] frame_cnt;
  logic [CW-1:0] idx;
  logic          dir;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt <= '0;
      idx       <= '0;
      dir       <= 1'b1;
    end else if (i_frame) begin
      if (frame_cnt == FW'(FRAME_CNT - 1)) begin
        frame_cnt <= '0;
        // Reverse at the endpoints by stepping away immediately.
        if (dir) begin
          if (idx == MAX) begin
            idx <= MAX - 1'b1;
            dir <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          if (idx == '0) begin
            idx <= CW'(1);
            dir <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign o_idx = idx;
  assign o_dir = dir;

endmodule

// File: rtl/pattern_display.sv
// VGA test-pattern generator: frame-latched mode select, active-area test and
// registered RGB output. Define PATTERN_DISPLAY_BORDER_EN to add a full-scale border.
module pattern_display
  import display_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int CW          = 4,
  parameter int FRAME_CNT   = 60,
  parameter int CHECK_SHIFT = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic signed [15:0]  i_x,
  input  logic signed [15:0]  i_y,
  input  logic                i_de,
  input  logic                i_frame,
  input  logic [1:0]          i_mode,
  output logic [CW-1:0]       o_r,
  output logic [CW-1:0]       o_g,
  output logic [CW-1:0]       o_b,
  output logic                o_de
);

  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  mode_e         mode_q;
  logic [CW-1:0] idx;
  logic          dir;
  logic [14:0]   xu, yu;
  logic          active;
  logic [2:0]    bar;
  logic [2:0]    mask;
  logic          check_px;
  logic [CW-1:0] r_d, g_d, b_d;

  color_cycler #(
    .CW        (CW),
    .FRAME_CNT (FRAME_CNT)
  ) u_cycler (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_frame (i_frame),
    .o_idx   (idx),
    .o_dir   (dir)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) mode_q <= MODE_GRADIENT;
    else if (i_frame) mode_q <= mode_e'(i_mode);
  end

  assign xu     = i_x[14:0];
  assign yu     = i_y[14:0];
  assign active = i_de && !i_x[15] && !i_y[15] &&
                  (xu < 15'(H_RES)) && (yu < 15'(V_RES));

  // Bar index from constant thresholds, avoiding a divider.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xu >= 15'((k * H_RES) / 8)) bar = 3'(k);
    end
  end

  assign mask     = BAR_RGB[bar];
  assign check_px = i_x[CHECK_SHIFT] ^ i_y[CHECK_SHIFT] ^ dir;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (mode_q)
      MODE_GRADIENT: begin
        r_d = idx;
        g_d = i_x[CW+3:4];
        b_d = i_y[CW+3:4];
      end
      MODE_BARS: begin
        r_d = {CW{mask[2]}};
        g_d = {CW{mask[1]}};
        b_d = {CW{mask[0]}};
      end
      MODE_CHECKER: begin
        r_d = {CW{check_px}};
        g_d = {CW{check_px}};
        b_d = {CW{check_px}};
      end
      default: begin
        r_d = idx;
        g_d = idx;
        b_d = idx;
      end
    endcase
`ifdef PATTERN_DISPLAY_BORDER_EN
    if (xu == 15'd0 || xu == 15'(H_RES - 1) || yu == 15'd0 || yu == 15'(V_RES - 1)) begin
      r_d = MAX;
      g_d = MAX;
      b_d = MAX;
    end
`endif
    if (!active) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_r  <= '0;
      o_g  <= '0;
      o_b  <= '0;
      o_de <= 1'b0;
    end else begin
      o_r  <= r_d;
      o_g  <= g_d;
      o_b  <= b_d;
      o_de <= i_de;
    end
  end

endmodule
